// File: rtl/fdiv_iter.sv
// fdiv_iter: iterative binary32 divider, s = a / b.
// Radix-2 restoring mantissa division, one quotient bit per clock, followed by
// a normalise/special-case cycle and a result-publish cycle. Every operation
// takes the same number of cycles.
// Optional build macro: FDIV_ROUND_EN (round half-up on the guard bit);
// without it the quotient mantissa is truncated.
//
// Handshake: a request is taken on a rising edge where start=1 and busy=0;
// a and b are sampled on that edge. busy stays high until the edge that
// raises done. done is a one-cycle pulse. s changes only on that edge and
// holds until the next done. A start seen during the done cycle is taken
// on the following edge.
module fdiv_iter (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] s,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        NORM = 2'd2,
        FIN  = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nxt;

    logic               load;
    logic               step;
    logic               norm_en;
    logic               fin;

    logic [4:0]         cnt;
    logic [24:0]        r;
    logic [23:0]        d;
    logic [25:0]        q;
    logic signed [9:0]  e;
    logic               sign;
    logic               za;
    logic               zb;
    logic [31:0]        res;

    logic               r_ge_d;
    logic [23:0]        r_diff;
    logic [22:0]        mant;
    logic signed [9:0]  exp_n;
    logic [22:0]        mant_f;
    logic signed [9:0]  exp_f;
    logic [31:0]        norm_res;

    assign state_dbg = state;

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state and per-state datapath enables.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        norm_en   = 1'b0;
        fin       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = DIV;
                end
            end
            DIV: begin
                step = 1'b1;
                if (cnt == 5'd25) state_nxt = NORM;
            end
            NORM: begin
                norm_en   = 1'b1;
                state_nxt = FIN;
            end
            FIN: begin
                fin       = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Restoring step. R < 2*D always holds, so the difference fits in 24 bits.
    always_comb begin
        r_ge_d = (r >= {1'b0, d});
        r_diff = r[23:0] - d;
    end

    // Normalise (quotient lies in (0.5, 2)), optional rounding, special cases.
`ifdef FDIV_ROUND_EN
    logic        guard;
    logic [23:0] mant_sum;
`endif
    always_comb begin
        if (q[25]) begin
            mant  = q[24:2];
            exp_n = e;
        end else begin
            mant  = q[23:1];
            exp_n = e - 10'sd1;
        end
`ifdef FDIV_ROUND_EN
        guard    = q[25] ? q[1] : q[0];
        mant_sum = {1'b0, mant} + {23'd0, guard};
        if (mant_sum[23]) begin
            mant_f = 23'd0;
            exp_f  = exp_n + 10'sd1;
        end else begin
            mant_f = mant_sum[22:0];
            exp_f  = exp_n;
        end
`else
        mant_f = mant;
        exp_f  = exp_n;
`endif
        if (zb)
            norm_res = {sign, 8'hFF, 23'h0};
        else if (za)
            norm_res = {sign, 31'h0};
        else if (exp_f <= 10'sd0)
            norm_res = {sign, 31'h0};
        else if (exp_f >= 10'sd255)
            norm_res = {sign, 8'hFF, 23'h0};
        else
            norm_res = {sign, exp_f[7:0], mant_f};
    end

    // Operand capture, iteration state, result staging and handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
            s    <= 32'h0;
            cnt  <= 5'd0;
            r    <= 25'd0;
            d    <= 24'd0;
            q    <= 26'd0;
            e    <= 10'sd0;
            sign <= 1'b0;
            za   <= 1'b0;
            zb   <= 1'b0;
            res  <= 32'h0;
        end else begin
            done <= 1'b0;
            if (load) begin
                busy <= 1'b1;
                sign <= a[31] ^ b[31];
                e    <= {2'b00, a[30:23]} - {2'b00, b[30:23]} + 10'd127;
                za   <= (a[30:23] == 8'd0);
                zb   <= (b[30:23] == 8'd0);
                r    <= {2'b01, a[22:0]};
                d    <= {1'b1, b[22:0]};
                q    <= 26'd0;
                cnt  <= 5'd0;
            end
            if (step) begin
                cnt <= cnt + 5'd1;
                if (r_ge_d) begin
                    q <= {q[24:0], 1'b1};
                    r <= {r_diff, 1'b0};
                end else begin
                    q <= {q[24:0], 1'b0};
                    r <= {r[23:0], 1'b0};
                end
            end
            if (norm_en) res <= norm_res;
            if (fin) begin
                s    <= res;
                done <= 1'b1;
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fdiv_iter.sv
// tb_fdiv_iter: directed bench for fdiv_iter. Expected results are hand
// computed constants, plus a small integer-division reference for a short
// sweep of normal operands. Honours FDIV_ROUND_EN.
module tb_fdiv_iter;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] s;
    logic [1:0]  state_dbg;

    int tests = 0;
    int fails = 0;
    int n;

    fdiv_iter dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .s         (s),
        .state_dbg (state_dbg)
    );

    // Clock.
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Reference: floor(ma * 2^25 / mb) gives the 26 quotient bits directly.
    function automatic logic [31:0] ref_div(input logic [31:0] av, input logic [31:0] bv);
        logic        sg;
        logic [63:0] qq;
        logic [22:0] mt;
        logic        g;
        int          ex;
        sg = av[31] ^ bv[31];
        if (bv[30:23] == 8'd0) return {sg, 8'hFF, 23'h0};
        if (av[30:23] == 8'd0) return {sg, 31'h0};
        qq = ({40'd1, av[22:0]} << 25) / {40'd1, bv[22:0]};
        ex = int'(av[30:23]) - int'(bv[30:23]) + 127;
        if (qq[25]) begin
            mt = qq[24:2];
            g  = qq[1];
        end else begin
            mt = qq[23:1];
            g  = qq[0];
            ex = ex - 1;
        end
`ifdef FDIV_ROUND_EN
        if (g) begin
            if (mt == 23'h7FFFFF) begin
                mt = 23'h0;
                ex = ex + 1;
            end else begin
                mt = mt + 23'd1;
            end
        end
`else
        g = 1'b0;
`endif
        if (ex <= 0)   return {sg, 31'h0};
        if (ex >= 255) return {sg, 8'hFF, 23'h0};
        return {sg, ex[7:0], mt};
    endfunction

    // Present a request and let the next rising edge accept it.
    task automatic issue(input string tag, input logic [31:0] av, input logic [31:0] bv);
        @(negedge clk);
        start = 1'b1;
        a     = av;
        b     = bv;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
    endtask

    // Count rising edges until done is seen (0 if not within 40 edges).
    task automatic wait_done(output int cnt_o);
        cnt_o = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                cnt_o = i;
                break;
            end
        end
    endtask

    task automatic run(input string tag, input logic [31:0] av, input logic [31:0] bv,
                       input logic [31:0] exp_v);
        int lat;
        issue(tag, av, bv);
        wait_done(lat);
        chk({tag, "_lat"}, lat, 32'd28);
        chk({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
        chk(tag, s, exp_v);
        @(posedge clk);
        #1;
        chk({tag, "_pulse"}, {31'd0, done}, 32'd0);
        chk({tag, "_hold"}, s, exp_v);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic [31:0] third;

`ifdef FDIV_ROUND_EN
        third = 32'h3EAAAAAB;
`else
        third = 32'h3EAAAAAA;
`endif

        // Reset.
        rst   = 1'b1;
        start = 1'b0;
        a     = 32'h0;
        b     = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_s", s, 32'h0);
        chk("rst_state", {30'd0, state_dbg}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Main function.
        run("six_by_two", 32'h40C00000, 32'h40000000, 32'h40400000);
        run("one_third", 32'h3F800000, 32'h40400000, third);
        run("neg_over_zero", 32'hBF800000, 32'h00000000, 32'hFF800000);
        run("zero_over_neg", 32'h00000000, 32'hC0000000, 32'h80000000);
        run("underflow", 32'h00800000, 32'h40000000, 32'h00000000);
        run("overflow", 32'h7F000000, 32'h3F000000, 32'h7F800000);
        run("neg_exact", 32'hC0F00000, 32'h40200000, 32'hC0400000);
        run("one_by_one", 32'h3F800000, 32'h3F800000, 32'h3F800000);
        run("denorm_a", 32'h00400000, 32'h3F800000, 32'h00000000);
        run("exp255_a", 32'h7FC00000, 32'h3F800000, 32'h7F800000);

        // Start during busy is ignored.
        issue("ignore", 32'h40C00000, 32'h40000000);
        repeat (4) @(posedge clk);
        @(negedge clk);
        start = 1'b1;
        a     = 32'h3F800000;
        b     = 32'h40400000;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(n);
        chk("ignore_lat", n, 32'd23);
        chk("ignore_s", s, 32'h40400000);

        // Start held high re-issues in the done cycle with the current operands.
        @(negedge clk);
        start = 1'b1;
        a     = 32'h40C00000;
        b     = 32'h40000000;
        @(posedge clk);
        #1;
        a = 32'hC0F00000;
        b = 32'h40200000;
        wait_done(n);
        chk("hold1_lat", n, 32'd28);
        chk("hold1_s", s, 32'h40400000);
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("hold2_busy", {31'd0, busy}, 32'd1);
        wait_done(n);
        chk("hold2_lat", n, 32'd28);
        chk("hold2_s", s, 32'hC0400000);

        // Asynchronous reset mid-operation.
        issue("abort", 32'h3F800000, 32'h40400000);
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_s", s, 32'h0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_state", {30'd0, state_dbg}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        wait_done(n);
        chk("abort_no_done", n, 32'd0);
        run("after_abort", 32'h40400000, 32'h3FC00000, 32'h40000000);

        // Short sweep of normal operands against the reference.
        for (int k = 0; k < 16; k++) begin
            ra = {1'($urandom_range(1, 0)), 8'($urandom_range(190, 64)), 23'($urandom)};
            rb = {1'($urandom_range(1, 0)), 8'($urandom_range(190, 64)), 23'($urandom)};
            run("sweep", ra, rb, ref_div(ra, rb));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
